// File: rtl/ccc_rst_pkg.sv
// Shared types and helpers for the CCC reset sequencer: FSM state encoding,
// loss-counter width and the sequencing-counter width calculation.
package ccc_rst_pkg;

    localparam int LOSS_W = 8;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Width large enough to hold the biggest terminal count of any active interval.
    function automatic int cnt_width(input int unsigned a, input int unsigned b,
                                     input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/ccc_rst_sync2.sv
// Two-flop synchronizer with synchronous active-high clear, for single-bit
// level signals crossing into clk.
module ccc_rst_sync2 (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/ccc_rst_sequencer.sv
// Fabric reset sequencer: waits for a stable CCC lock, then releases staged
// active-low resets. Optional lock watchdog: CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN.
module ccc_rst_sequencer
    import ccc_rst_pkg::*;
#(
    parameter int unsigned NUM_STAGES          = 3,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP_CYCLES    = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CCC_LOCK,
    input  logic                  SW_RESET_REQ,
    output logic [NUM_STAGES-1:0] STAGE_RSTN,
    output logic                  READY,
    output logic                  LOCK_LOST,
    output logic [LOSS_W-1:0]     LOSS_COUNT,
    output logic                  FAULT
);

`ifdef CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int unsigned WD_SPAN  = WD_EN ? LOCK_TIMEOUT_CYCLES : 1;
    localparam int unsigned REL_SPAN = (NUM_STAGES - 1) * STAGE_GAP_CYCLES + 1;
    localparam int          CW       = cnt_width(LOCK_STABLE_CYCLES, REL_SPAN, WD_SPAN);

    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'((NUM_STAGES - 1) * STAGE_GAP_CYCLES);
`ifdef CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    logic                  lock_s;
    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic                  cnt_run;
    logic [NUM_STAGES-1:0] stage_rstn_reg, stage_rstn_next;
    logic [NUM_STAGES-1:0] stage_due;
    logic                  ready_reg, ready_next;
    logic                  lock_lost_reg, lock_lost_next;
    logic [LOSS_W-1:0]     loss_count_reg, loss_count_next;
    logic                  loss_event;
`ifdef CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN
    logic                  fault_reg, fault_next;
`endif

    ccc_rst_sync2 u_lock_sync (
        .clk  (CLK),
        .srst (RESET),
        .d    (CCC_LOCK),
        .q    (lock_s)
    );

    // Stage k (k>=1) goes high on the edge where the RELEASE count reaches k*gap.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_due
            if (gi == 0) begin : g_first
                assign stage_due[gi] = 1'b0;
            end else begin : g_rest
                localparam logic [CW-1:0] DUE = CW'(gi * STAGE_GAP_CYCLES - 1);
                assign stage_due[gi] = (cnt_reg == DUE);
            end
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        cnt_run         = 1'b0;
        stage_rstn_next = stage_rstn_reg;
        lock_lost_next  = lock_lost_reg;
        loss_count_next = loss_count_reg;
        loss_event      = 1'b0;
`ifdef CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN
        fault_next      = fault_reg;
`endif

        case (state_reg)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_next = ST_STABLE;
                end else begin
`ifdef CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN
                    if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = ST_FAULT;
                        fault_next = 1'b1;
                    end else begin
                        cnt_run = 1'b1;
                    end
`endif
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    loss_event = 1'b1;
                end else if (SW_RESET_REQ) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next         = ST_RELEASE;
                    stage_rstn_next[0] = 1'b1;
                end else begin
                    cnt_run = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!lock_s) begin
                    loss_event = 1'b1;
                end else if (SW_RESET_REQ) begin
                    state_next = ST_WAIT_LOCK;
                end else begin
                    stage_rstn_next = stage_rstn_reg | stage_due;
                    if (cnt_reg == RELEASE_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        cnt_run = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    loss_event = 1'b1;
                end else if (SW_RESET_REQ) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
`ifdef CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN
            ST_FAULT: begin
                if (SW_RESET_REQ) begin
                    state_next = ST_WAIT_LOCK;
                    fault_next = 1'b0;
                end
            end
`endif
            default: begin
                state_next = ST_WAIT_LOCK;
            end
        endcase

        // Lock loss outranks a coincident software request and is counted once.
        if (loss_event) begin
            state_next     = ST_WAIT_LOCK;
            lock_lost_next = 1'b1;
            if (loss_count_reg != {LOSS_W{1'b1}}) begin
                loss_count_next = loss_count_reg + 1'b1;
            end
        end

        if (state_next == ST_WAIT_LOCK || state_next == ST_FAULT) begin
            stage_rstn_next = '0;
        end

        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_run) begin
            cnt_next = cnt_reg + 1'b1;
        end

        ready_next = (state_next == ST_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg      <= ST_WAIT_LOCK;
            cnt_reg        <= '0;
            stage_rstn_reg <= '0;
            ready_reg      <= 1'b0;
            lock_lost_reg  <= 1'b0;
            loss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            stage_rstn_reg <= stage_rstn_next;
            ready_reg      <= ready_next;
            lock_lost_reg  <= lock_lost_next;
            loss_count_reg <= loss_count_next;
        end
    end

`ifdef CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_next;
        end
    end
    assign FAULT = fault_reg;
`else
    assign FAULT = 1'b0;
`endif

    assign STAGE_RSTN = stage_rstn_reg;
    assign READY      = ready_reg;
    assign LOCK_LOST  = lock_lost_reg;
    assign LOSS_COUNT = loss_count_reg;

endmodule

// File: tb/tb_ccc_rst_sequencer.sv
// Directed bench for ccc_rst_sequencer with stable=16, gap=4, 3 stages,
// timeout=100; expected timings are hand-derived from the lock edge.
module tb_ccc_rst_sequencer;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lock = 1'b0;
    logic          sw = 1'b0;
    logic [NS-1:0] stage_rstn;
    logic          ready;
    logic          lock_lost;
    logic [7:0]    loss_count;
    logic          fault;

    int errors = 0;
    int checks = 0;

    ccc_rst_sequencer #(
        .NUM_STAGES          (NS),
        .LOCK_STABLE_CYCLES  (16),
        .STAGE_GAP_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (100)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .CCC_LOCK     (lock),
        .SW_RESET_REQ (sw),
        .STAGE_RSTN   (stage_rstn),
        .READY        (ready),
        .LOCK_LOST    (lock_lost),
        .LOSS_COUNT   (loss_count),
        .FAULT        (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("pass %s: %0h", tag, got);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full release sequence from WAIT_LOCK with lock_s low: lock rises now (edge E),
    // STABLE at E+3, stage0 at E+19, stage1 at E+23, stage2 at E+27, READY at E+28.
    task automatic seq_check(input string tag, input logic [7:0] exp_loss);
        lock = 1'b1;
        step(18); chk({tag, "_pre_s0"}, stage_rstn, 3'b000);
        step(1);  chk({tag, "_s0"}, stage_rstn, 3'b001);
        step(3);  chk({tag, "_pre_s1"}, stage_rstn, 3'b001);
        step(1);  chk({tag, "_s1"}, stage_rstn, 3'b011);
        step(3);  chk({tag, "_pre_s2"}, stage_rstn, 3'b011);
        step(1);  chk({tag, "_s2"}, stage_rstn, 3'b111);
                  chk({tag, "_ready_lo"}, ready, 1'b0);
        step(1);  chk({tag, "_ready_hi"}, ready, 1'b1);
                  chk({tag, "_loss"}, loss_count, exp_loss);
    endtask

    initial begin
        step(3);
        chk("rst_stage", stage_rstn, 3'b000);
        chk("rst_ready", ready, 1'b0);
        chk("rst_lock_lost", lock_lost, 1'b0);
        chk("rst_loss", loss_count, 8'd0);
        chk("rst_fault", fault, 1'b0);
        rst = 1'b0;

`ifdef CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN
        step(99); chk("wd_fault_pre", fault, 1'b0);
        step(1);  chk("wd_fault_set", fault, 1'b1);
                  chk("wd_fault_stage", stage_rstn, 3'b000);
        sw = 1'b1;
        step(1);  sw = 1'b0;
                  chk("wd_fault_clr", fault, 1'b0);
`else
        step(150); chk("nowd_fault", fault, 1'b0);
                   chk("nowd_stage", stage_rstn, 3'b000);
`endif

        // One-cycle lock glitch while in STABLE
        lock = 1'b1;
        step(8);  chk("gl_in_stable", stage_rstn, 3'b000);
        lock = 1'b0;
        step(1);  lock = 1'b1;
        step(2);  chk("gl_loss", loss_count, 8'd1);
                  chk("gl_lock_lost", lock_lost, 1'b1);
                  chk("gl_stage", stage_rstn, 3'b000);
        step(16); chk("gl_pre_s0", stage_rstn, 3'b000);
        step(1);  chk("gl_s0", stage_rstn, 3'b001);
        step(8);  chk("gl_s2", stage_rstn, 3'b111);
                  chk("gl_ready_lo", ready, 1'b0);
        step(1);  chk("gl_ready_hi", ready, 1'b1);

        // Lock drop in RUN
        lock = 1'b0;
        step(2);  chk("drop_hold_stage", stage_rstn, 3'b111);
                  chk("drop_hold_ready", ready, 1'b1);
        step(1);  chk("drop_stage", stage_rstn, 3'b000);
                  chk("drop_ready", ready, 1'b0);
                  chk("drop_loss", loss_count, 8'd2);
        seq_check("relock1", 8'd2);

        // Software request alone in RUN
        sw = 1'b1;
        step(1);  sw = 1'b0;
                  chk("sw_stage", stage_rstn, 3'b000);
                  chk("sw_ready", ready, 1'b0);
                  chk("sw_loss", loss_count, 8'd2);
        step(16); chk("sw_pre_s0", stage_rstn, 3'b000);
        step(1);  chk("sw_s0", stage_rstn, 3'b001);
        step(8);  chk("sw_s2", stage_rstn, 3'b111);
        step(1);  chk("sw_ready_hi", ready, 1'b1);

        // Software request in the same cycle the synchronized lock drops
        lock = 1'b0;
        step(2);  sw = 1'b1;
        step(1);  sw = 1'b0;
                  chk("co_stage", stage_rstn, 3'b000);
                  chk("co_ready", ready, 1'b0);
                  chk("co_loss", loss_count, 8'd3);
                  chk("co_lock_lost", lock_lost, 1'b1);
        seq_check("relock2", 8'd3);

        // 300 forced losses saturate the counter
        for (int i = 0; i < 300; i++) begin
            lock = 1'b1;
            step(4);
            lock = 1'b0;
            step(3);
            if (i == 99) chk("sat_mid", loss_count, 8'd103);
        end
        chk("sat_loss", loss_count, 8'd255);
        chk("sat_lock_lost", lock_lost, 1'b1);
        chk("sat_stage", stage_rstn, 3'b000);

        rst = 1'b1;
        step(1);  chk("clr_loss", loss_count, 8'd0);
                  chk("clr_lock_lost", lock_lost, 1'b0);
                  chk("clr_ready", ready, 1'b0);
        rst = 1'b0;

        // Reset in the middle of RELEASE
        lock = 1'b1;
        step(23); chk("mid_s1", stage_rstn, 3'b011);
        step(1);  chk("mid_hold", stage_rstn, 3'b011);
        rst = 1'b1;
        step(1);  chk("mid_rst_stage", stage_rstn, 3'b000);
                  chk("mid_rst_ready", ready, 1'b0);
        rst = 1'b0;
        lock = 1'b0;
        seq_check("post_rst", 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccc_rst_sequencer.md
# ccc_rst_sequencer

Reset sequencer for the fabric clock domain driven by the on-chip 25/50 MHz RC oscillator through the CCC. It waits for CCC lock and requires a programmable stable-lock interval. It then releases a set of active-low domain resets in a fixed staged order and re-asserts all of them if lock drops. It sits between the oscillator/CCC core and every fabric block that consumes the CCC output clock.

## Interface
Parameters:
- NUM_STAGES, 3: number of staged reset outputs, 1..8.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release, ≥1.
- STAGE_GAP_CYCLES, 64: cycles between successive stage releases, ≥1.
- LOCK_TIMEOUT_CYCLES, 65536: WAIT_LOCK timeout. Only used with the watchdog macro.

Ports:
- CLK  in  1  fabric clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high; overrides everything.
- CCC_LOCK  in  1  CCC lock indicator, asynchronous to CLK.
- SW_RESET_REQ  in  1  single-cycle pulse; requests a full re-sequence.
- STAGE_RSTN  out  NUM_STAGES  active-low domain resets; bit 0 releases first.
- READY  out  1  high while in RUN (all stages released).
- LOCK_LOST  out  1  sticky flag, set on any lock loss after STABLE was entered.
- LOSS_COUNT  out  8  saturating count of lock-loss events.
- FAULT  out  1  lock-timeout fault (watchdog build only; otherwise constant 0).

## Operation
- CCC_LOCK passes through a 2-flop synchronizer; lock_s is the synchronized value.
- States: WAIT_LOCK, STABLE, RELEASE, RUN, plus FAULT in the watchdog build.
- WAIT_LOCK: all STAGE_RSTN = 0. When lock_s = 1, go to STABLE and clear the counter.
- STABLE: the counter increments each cycle while lock_s = 1. At LOCK_STABLE_CYCLES-1, go to RELEASE. If lock_s = 0, go to WAIT_LOCK and count a loss.
- RELEASE: STAGE_RSTN[k] deasserts k*STAGE_GAP_CYCLES cycles after RELEASE entry; bit 0 deasserts on entry. Once already-released bits go high, they stay high. One cycle after the last bit releases, go to RUN.
- RUN: READY = 1. The FSM holds here until lock loss or SW_RESET_REQ.
- Lock loss (lock_s = 0 in STABLE, RELEASE or RUN):
  - Assert all STAGE_RSTN on the next edge and go to WAIT_LOCK.
  - Set LOCK_LOST and increment LOSS_COUNT, saturating at 255.
- SW_RESET_REQ in STABLE, RELEASE or RUN: assert all STAGE_RSTN and go to WAIT_LOCK. No loss is counted. In WAIT_LOCK the request is ignored.
- Simultaneous lock loss and SW_RESET_REQ: lock loss takes priority and is counted once.
- Reset values: STAGE_RSTN all 0, READY 0, LOCK_LOST 0, LOSS_COUNT 0, FAULT 0, state WAIT_LOCK, synchronizer flops 0.
- RESET asserted mid-release: all outputs return to reset values on the next edge.

## Timing
- All outputs are registered.
- CCC_LOCK rising to STABLE entry: 3 cycles (2 synchronizer cycles + 1 state register cycle).
- Stable lock to stage 0 release: LOCK_STABLE_CYCLES cycles after STABLE entry.
- Stage k release: k*STAGE_GAP_CYCLES cycles after stage 0 release.
- READY rises 1 cycle after the last stage releases.
- CCC_LOCK falling to all STAGE_RSTN low and READY low: at most 3 cycles.
- Counter width: clog2 of the largest active parameter + 1. The counter clears on every state change.

## Configuration
- Macro: CCC_RST_SEQUENCER_LOCK_WATCHDOG_EN.
- Defined:
  - WAIT_LOCK counts cycles. Reaching LOCK_TIMEOUT_CYCLES without lock_s sets FAULT = 1 and enters FAULT.
  - In FAULT, all resets stay asserted and lock_s is ignored.
  - SW_RESET_REQ clears FAULT and returns the FSM to WAIT_LOCK; RESET also leaves FAULT.
- Undefined: WAIT_LOCK waits indefinitely, FAULT is tied to 0, and no timeout counter is built.

## Structure
- Shared package ccc_rst_pkg holds:
  - the state enum (WAIT_LOCK, STABLE, RELEASE, RUN, FAULT);
  - the LOSS_COUNT width constant (8);
  - the counter-width function.
- One sub-module, ccc_rst_sync2: a parameterless 2-flop synchronizer with a synchronous active-high reset to 0.

## Test plan
Use NUM_STAGES=3, LOCK_STABLE_CYCLES=16, STAGE_GAP_CYCLES=4, LOCK_TIMEOUT_CYCLES=100.
- Lock at cycle 10, held high -> STAGE_RSTN[0] at 10+3+16, [1] at +4, [2] at +8; READY 1 cycle after [2]; LOSS_COUNT 0.
- Lock glitches low for 1 cycle during STABLE -> return to WAIT_LOCK, LOSS_COUNT=1, LOCK_LOST=1, no stage released; full sequence restarts on relock.
- Lock drops in RUN -> all STAGE_RSTN=0 and READY=0 within 3 cycles; LOSS_COUNT increments; re-sequence on relock.
- SW_RESET_REQ in RUN, coincident with lock drop on another run -> resets asserted in both cases; LOSS_COUNT unchanged for SW-only, +1 for coincident.
- 300 forced lock losses -> LOSS_COUNT saturates at 255; RESET clears it and LOCK_LOST to 0.
- Watchdog build, lock never asserts -> FAULT=1 at cycle 100 of WAIT_LOCK; SW_RESET_REQ clears FAULT; later lock produces a normal sequence. Non-watchdog build -> FAULT stays 0 forever.
